// File: rtl/mem_writeback.sv
// Final scalar pipeline stage: retires REG/MEM/BR/DONE ops, drives memctrl loads/stores with byte enables,
// extends load data, redirects IFetch and writes SReg. Optional macro WB_MISALIGN_CHK_EN adds a misalign trap.
module mem_writeback #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rd_rdy,
  output logic              wb_rdy,
  input  logic [1:0]        op_type,
  input  logic              is_jalr,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_uns,
  input  logic [RA_W-1:0]   rd,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   val,
  input  logic [XLEN-1:0]   st_data,
  output logic              br_rdy,
  output logic [XLEN-1:0]   pc_out,
  output logic [RA_W-1:0]   reg_rd,
  output logic [XLEN-1:0]   reg_out,
  output logic [1:0]        mem_wr,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_data,
  input  logic              mem_rdy,
  input  logic [XLEN-1:0]   ld_data,
  output logic              halt
`ifdef WB_MISALIGN_CHK_EN
  ,
  output logic              misalign
`endif
);

  localparam int BE_W = XLEN / 8;
  localparam int LB   = $clog2(BE_W);

  localparam logic [1:0] OP_REG  = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_DONE = 2'b11;

  localparam logic [1:0] WR_IDLE  = 2'b00;
  localparam logic [1:0] WR_LOAD  = 2'b10;
  localparam logic [1:0] WR_STORE = 2'b11;

  typedef enum logic [1:0] {IDLE, LD, ST} state_t;

  state_t            state_q, state_n;
  logic              wb_rdy_n, br_rdy_n, halt_n;
  logic [XLEN-1:0]   pc_out_n, reg_out_n, mem_addr_n, mem_data_n;
  logic [RA_W-1:0]   reg_rd_n, rd_q, rd_qn;
  logic [1:0]        mem_wr_n, size_q, size_qn;
  logic [BE_W-1:0]   mem_be_n;
  logic              uns_q, uns_qn;
  logic              accept;
  logic [XLEN-1:0]   ld_shifted;

  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return BE_W'(1);
      2'b01:   return BE_W'(3);
      default: return {BE_W{1'b1}};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] sz,
                                             input logic uns);
    case (sz)
      2'b00:   return uns ? {{(XLEN-8){1'b0}}, d[7:0]}   : {{(XLEN-8){d[7]}}, d[7:0]};
      2'b01:   return uns ? {{(XLEN-16){1'b0}}, d[15:0]} : {{(XLEN-16){d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return {(XLEN/8){d[7:0]}};
      2'b01:   return {(XLEN/16){d[15:0]}};
      default: return d;
    endcase
  endfunction

`ifdef WB_MISALIGN_CHK_EN
  logic misalign_n;
  logic mis_acc;

  // Halves must sit on even bytes; words must start at lane 0 so they never straddle the bus word.
  always_comb begin
    mis_acc = 1'b0;
    if (mem_size == 2'b01)
      mis_acc = val[0];
    else if (mem_size[1])
      mis_acc = (val[LB-1:0] != '0);
  end
`endif

  assign accept     = rd_rdy & wb_rdy;
  assign ld_shifted = ld_data >> {mem_addr[LB-1:0], 3'b000};

  always_comb begin
    state_n    = state_q;
    wb_rdy_n   = wb_rdy;
    br_rdy_n   = 1'b0;
    reg_rd_n   = '0;
    pc_out_n   = pc_out;
    reg_out_n  = reg_out;
    mem_wr_n   = mem_wr;
    mem_addr_n = mem_addr;
    mem_be_n   = mem_be;
    mem_data_n = mem_data;
    halt_n     = halt;
    rd_qn      = rd_q;
    size_qn    = size_q;
    uns_qn     = uns_q;
`ifdef WB_MISALIGN_CHK_EN
    misalign_n = misalign;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_type)
            OP_REG: begin
              reg_rd_n = rd;
              if (is_jalr) begin
                reg_out_n = pc + XLEN'(4);
                pc_out_n  = val & ~XLEN'(1);
                br_rdy_n  = 1'b1;
              end else begin
                reg_out_n = val;
              end
            end
            OP_BR: begin
              br_rdy_n = 1'b1;
              pc_out_n = (val != '0) ? pc + imm : pc + XLEN'(4);
            end
            OP_MEM: begin
              mem_addr_n = val;
              mem_be_n   = size_mask(mem_size) << val[LB-1:0];
              wb_rdy_n   = 1'b0;
              rd_qn      = rd;
              size_qn    = mem_size;
              uns_qn     = mem_uns;
              if (mem_we) begin
                mem_data_n = replicate(st_data, mem_size);
                mem_wr_n   = WR_STORE;
                state_n    = ST;
              end else begin
                mem_wr_n   = WR_LOAD;
                state_n    = LD;
              end
`ifdef WB_MISALIGN_CHK_EN
              // A trapped access never reaches memctrl; the stage halts instead.
              if (mis_acc) begin
                mem_be_n   = '0;
                mem_wr_n   = WR_IDLE;
                state_n    = IDLE;
                misalign_n = 1'b1;
                halt_n     = 1'b1;
              end
`endif
            end
            OP_DONE: begin
              halt_n   = 1'b1;
              wb_rdy_n = 1'b0;
            end
            default: ;
          endcase
        end
      end
      LD: begin
        if (mem_rdy) begin
          reg_out_n = extend(ld_shifted, size_q, uns_q);
          reg_rd_n  = rd_q;
          mem_wr_n  = WR_IDLE;
          mem_be_n  = '0;
          state_n   = IDLE;
          wb_rdy_n  = 1'b1;
        end
      end
      ST: begin
        if (mem_rdy) begin
          mem_wr_n = WR_IDLE;
          mem_be_n = '0;
          state_n  = IDLE;
          wb_rdy_n = 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        mem_wr_n = WR_IDLE;
        mem_be_n = '0;
        wb_rdy_n = ~halt;
      end
    endcase
  end

  // Reset wins over the global enable so a stalled pipe can still be aborted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wb_rdy   <= 1'b1;
      br_rdy   <= 1'b0;
      reg_rd   <= '0;
      pc_out   <= '0;
      reg_out  <= '0;
      mem_wr   <= WR_IDLE;
      mem_addr <= '0;
      mem_be   <= '0;
      mem_data <= '0;
      halt     <= 1'b0;
      rd_q     <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
`ifdef WB_MISALIGN_CHK_EN
      misalign <= 1'b0;
`endif
    end else if (rdy) begin
      state_q  <= state_n;
      wb_rdy   <= wb_rdy_n;
      br_rdy   <= br_rdy_n;
      reg_rd   <= reg_rd_n;
      pc_out   <= pc_out_n;
      reg_out  <= reg_out_n;
      mem_wr   <= mem_wr_n;
      mem_addr <= mem_addr_n;
      mem_be   <= mem_be_n;
      mem_data <= mem_data_n;
      halt     <= halt_n;
      rd_q     <= rd_qn;
      size_q   <= size_qn;
      uns_q    <= uns_qn;
`ifdef WB_MISALIGN_CHK_EN
      misalign <= misalign_n;
`endif
    end
  end

endmodule
